seg7_capture: RTL

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// Captures the four digits of a multiplexed, active-low 7-segment display and
// publishes them as one 16-bit hex frame once every digit has been seen legally.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] hex_out,
    output logic        frame_valid,
    output logic        digit_err,
    output logic [7:0]  err_count
);

    typedef enum logic {
        COLLECT,
        PUBLISH
    } state_e;

    localparam logic [3:0] STABLE_RUN = 4'(STABLE_CYCLES);

    logic [10:0] sync1_q, sync2_q, prev_q;
    logic [3:0]  run_q, run_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] staging_q, staging_d;
    logic [15:0] hex_q, hex_d;
    logic        digit_err_q, digit_err_d;
    logic [7:0]  err_count_q, err_count_d;
    state_e      state_q, state_d;

    logic        slot_valid, accept, code_legal, blank;
    logic [1:0]  slot;
    logic [3:0]  code_val;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            prev_q      <= '1;
            run_q       <= '0;
            mask_q      <= '0;
            staging_q   <= '0;
            hex_q       <= '0;
            digit_err_q <= 1'b0;
            err_count_q <= '0;
            state_q     <= COLLECT;
        end else begin
            sync1_q     <= {an, seg};
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            run_q       <= run_d;
            mask_q      <= mask_d;
            staging_q   <= staging_d;
            hex_q       <= hex_d;
            digit_err_q <= digit_err_d;
            err_count_q <= err_count_d;
            state_q     <= state_d;
        end
    end

    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        run_d = run_q;
        if (sync2_q != prev_q) begin
            run_d = 4'd1;
        end else if (run_q != STABLE_RUN) begin
            run_d = run_q + 4'd1;
        end

        slot_valid = 1'b1;
        slot       = 2'd0;
        case (sync2_q[10:7])
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: slot_valid = 1'b0;
        endcase

        // Fires once per dwell: only on the edge the run count reaches the threshold.
        accept = slot_valid && (run_d == STABLE_RUN) && (run_q != STABLE_RUN);

        code_legal = 1'b1;
        code_val   = 4'h0;
        case (sync2_q[6:0])
            7'b0000001: code_val = 4'h0;
            7'b1001111: code_val = 4'h1;
            7'b0010010: code_val = 4'h2;
            7'b0000110: code_val = 4'h3;
            7'b1001100: code_val = 4'h4;
            7'b0100100: code_val = 4'h5;
            7'b0100000: code_val = 4'h6;
            7'b0001111: code_val = 4'h7;
            7'b0000000: code_val = 4'h8;
            7'b0001100: code_val = 4'h9;
            7'b0001000: code_val = 4'hA;
            7'b1100000: code_val = 4'hB;
            7'b0110001: code_val = 4'hC;
            7'b1000010: code_val = 4'hD;
            7'b0110000: code_val = 4'hE;
            7'b0111000: code_val = 4'hF;
            default:    code_legal = 1'b0;
        endcase
        blank = (sync2_q[6:0] == 7'b1111111);

        // The publish-cycle clear happens first so a coincident capture survives it.
        mask_d      = (state_q == PUBLISH) ? 4'b0000 : mask_q;
        staging_d   = staging_q;
        digit_err_d = 1'b0;
        err_count_d = err_count_q;
        if (accept) begin
            if (code_legal) begin
                staging_d[{slot, 2'b00} +: 4] = code_val;
                mask_d[slot]                  = 1'b1;
            end else begin
                mask_d[slot] = 1'b0;
                if (!blank) begin
                    digit_err_d = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
        end

        state_d = state_q;
        hex_d   = hex_q;
        case (state_q)
            COLLECT: begin
                if (mask_d == 4'b1111) begin
                    state_d = PUBLISH;
                    hex_d   = staging_d;
                end
            end
            PUBLISH: state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    assign hex_out     = hex_q;
    assign frame_valid = (state_q == PUBLISH);
    assign digit_err   = digit_err_q;
    assign err_count   = err_count_q;

endmodule
